// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared types for the ALU micro-sequencer
package alu_sequencer_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
        OP_PASS_A, OP_PASS_B, OP_INC, OP_DEC, OP_CMP, OP_NEG, OP_NOP, OP_CLR
    } operation;

    typedef struct packed {
        operation   op;
        logic [3:0] mux_addr;
        logic [2:0] rf_ce;
        logic       acc_ce;
        logic       end_flag;
        logic [2:0] rep;
    } instr_t;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} seq_state_t;

endpackage

// File: rtl/alu_seq_prog_mem.sv
// alu_seq_prog_mem: single-port program RAM, synchronous write and synchronous read
module alu_seq_prog_mem
    import alu_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_addr,
    input  logic [INSTR_W-1:0] i_wdata,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // The single port either writes or reads in a given cycle; contents are never reset
    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_addr] <= i_wdata;
        else      o_rdata <= mem_q[i_addr];
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: program-RAM driven micro-sequencer for the ALU control inputs
// Optional ALU_SEQ_STEP_EN adds i_step; issues then advance only on cycles with i_step=1.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int PC_W       = $clog2(PROG_DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_prog_we,
    input  logic [PC_W-1:0]    i_prog_addr,
    input  logic [INSTR_W-1:0] i_prog_data,
`ifdef ALU_SEQ_STEP_EN
    input  logic               i_step,
`endif
    output logic               o_busy,
    output logic               o_done,
    output logic [PC_W-1:0]    o_pc,
    output operation           o_operation_code,
    output logic               o_acumulator_ce,
    output logic [2:0]         o_register_file_ce,
    output logic [3:0]         o_register_file_mux_addr
);

    logic step;
`ifdef ALU_SEQ_STEP_EN
    assign step = i_step;
`else
    assign step = 1'b1;
`endif

    seq_state_t         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [2:0]         rep_q, rep_d;
    logic               first_q, first_d, rvalid_q, we_en, issue;
    instr_t             cur_q, cur_d, word;
    logic [INSTR_W-1:0] rdata;
    operation           op_q;
    logic [3:0]         mux_q;
    logic [2:0]         rf_ce_q;
    logic               acc_ce_q, busy_q, done_q;

    // The RAM is addressed with the next pc so the word is ready during FETCH;
    // a host write steals the port, which rvalid_q records so FETCH can retry.
    assign we_en = i_prog_we && state_q != FETCH && state_q != ISSUE;
    assign word  = first_q ? instr_t'(rdata) : cur_q;
    assign issue = state_d == ISSUE;

    alu_seq_prog_mem #(.DEPTH(PROG_DEPTH)) u_mem (
        .i_clk   (i_clk),
        .i_we    (we_en),
        .i_addr  (we_en ? i_prog_addr : pc_d),
        .i_wdata (i_prog_data),
        .o_rdata (rdata)
    );

    // Next-state logic: first_q marks a freshly fetched word whose repeat count is not yet loaded
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rep_d   = rep_q;
        first_d = first_q;
        cur_d   = cur_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d = FETCH;
                pc_d    = '0;
                first_d = 1'b1;
            end
            FETCH: if (step && rvalid_q) begin
                state_d = ISSUE;
                cur_d   = word;
                rep_d   = first_q ? word.rep : rep_q - 3'd1;
                first_d = 1'b0;
            end
            ISSUE: if (rep_q != 3'd0) begin
                state_d = step ? ISSUE : FETCH;
                rep_d   = step ? rep_q - 3'd1 : rep_q;
            end else if (cur_q.end_flag || pc_q == PC_W'(PROG_DEPTH - 1)) begin
                state_d = DONE;
            end else begin
                state_d = FETCH;
                pc_d    = pc_q + PC_W'(1);
                first_d = 1'b1;
            end
            DONE: state_d = IDLE;
        endcase
    end

    // State and registered ALU controls; CEs only assert in ISSUE, op/mux hold otherwise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            rep_q    <= '0;
            first_q  <= 1'b0;
            rvalid_q <= 1'b0;
            cur_q    <= '0;
            op_q     <= operation'(0);
            mux_q    <= '0;
            rf_ce_q  <= '0;
            acc_ce_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rep_q    <= rep_d;
            first_q  <= first_d;
            rvalid_q <= !we_en;
            cur_q    <= cur_d;
            op_q     <= issue ? cur_d.op : op_q;
            mux_q    <= issue ? cur_d.mux_addr : mux_q;
            rf_ce_q  <= issue ? cur_d.rf_ce : 3'd0;
            acc_ce_q <= issue && cur_d.acc_ce;
            busy_q   <= state_d == FETCH || state_d == ISSUE;
            done_q   <= state_d == DONE;
        end
    end

    assign o_busy                   = busy_q;
    assign o_done                   = done_q;
    assign o_pc                     = pc_q;
    assign o_operation_code         = op_q;
    assign o_acumulator_ce          = acc_ce_q;
    assign o_register_file_ce       = rf_ce_q;
    assign o_register_file_mux_addr = mux_q;

endmodule
